// File: rtl/cla_64bit.sv
// 64-bit two-level carry-lookahead adder with registered Sum/Cout.
// Carries come from 4-bit lookahead cells: 16 bit groups, 4 block units, and one top unit.
module cla_64bit (
    input  logic        clock,
    input  logic        reset_n,
    output logic [63:0] Sum,
    output logic        Cout,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        Cin
);

    // Group generate/propagate for a 4-wide slice: {G, P}
    function automatic logic [1:0] gp4(input logic [3:0] g, input logic [3:0] p);
        logic gg;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {gg, &p};
    endfunction

    // Lookahead carries into the four positions of a slice; bit 0 is the slice carry-in
    function automatic logic [3:0] carry4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    logic [63:0] g, p, c, s;
    logic [15:0] grp_g, grp_p, grp_c;
    logic [3:0]  blk_g, blk_p, blk_c;
    logic        top_g, top_p, c64;

    // G/P flow upward first, then carries flow back down through the same cells
    always_comb begin
        g = A & B;
        p = A ^ B;
        for (int unsigned j = 0; j < 16; j++)
            {grp_g[j], grp_p[j]} = gp4(g[4*j +: 4], p[4*j +: 4]);
        for (int unsigned k = 0; k < 4; k++)
            {blk_g[k], blk_p[k]} = gp4(grp_g[4*k +: 4], grp_p[4*k +: 4]);
        {top_g, top_p} = gp4(blk_g, blk_p);
        blk_c = carry4(blk_g, blk_p, Cin);
        c64   = top_g | (top_p & Cin);
        for (int unsigned k = 0; k < 4; k++)
            grp_c[4*k +: 4] = carry4(grp_g[4*k +: 4], grp_p[4*k +: 4], blk_c[k]);
        for (int unsigned j = 0; j < 16; j++)
            c[4*j +: 4] = carry4(g[4*j +: 4], p[4*j +: 4], grp_c[j]);
        s = p ^ c;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            Sum  <= '0;
            Cout <= 1'b0;
        end else begin
            Sum  <= s;
            Cout <= c64;
        end
    end

endmodule

// File: tb/tb_cla_64bit.sv
// Self-checking bench for cla_64bit against a 65-bit arithmetic reference model.
module tb_cla_64bit;

    logic        clock;
    logic        reset_n;
    logic [63:0] Sum;
    logic        Cout;
    logic [63:0] A, B;
    logic        Cin;

    int unsigned errors = 0;
    int unsigned checks = 0;

    cla_64bit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .Sum     (Sum),
        .Cout    (Cout),
        .A       (A),
        .B       (B),
        .Cin     (Cin)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {Cout,Sum}=%h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b, input logic ci);
        return {1'b0, a} + {1'b0, b} + {64'd0, ci};
    endfunction

    // Present operands, take one rising edge, then check the registered result
    task automatic step(input string tag, input logic [63:0] a, input logic [63:0] b, input logic ci);
        A = a; B = b; Cin = ci;
        @(posedge clock);
        #1;
        check(tag, {Cout, Sum}, model(a, b, ci));
    endtask

    initial begin
        reset_n = 1'b0;
        A = '0; B = '0; Cin = 1'b0;
        #1;
        check("reset_zero", {Cout, Sum}, 65'd0);
        @(posedge clock);
        #1;
        check("reset_hold_edge", {Cout, Sum}, 65'd0);
        reset_n = 1'b1;
        step("release_zero", 64'd0, 64'd0, 1'b0);

        for (int unsigned i = 0; i <= 200; i++)
            step("sweep", 64'(i), 64'd0, 1'b0);

        step("chain_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        check("chain_cin_const", {Cout, Sum}, {1'b1, 64'd0});
        step("chain_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check("chain_all_const", {Cout, Sum}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});

        step("grp_bound", 64'h0000_0000_0000_000F, 64'd1, 1'b0);
        check("grp_bound_const", {Cout, Sum}, 65'h10);
        step("blk_bound", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
        check("blk_bound_const", {Cout, Sum}, 65'h1_0000);
        step("top_bound", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        check("top_bound_const", {Cout, Sum}, 65'h1_0000_0000_0000);

        step("pre_reset", 64'd5, 64'd7, 1'b1);
        check("pre_reset_const", {Cout, Sum}, 65'd13);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {Cout, Sum}, 65'd0);
        A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'd3; Cin = 1'b1;
        @(posedge clock);
        #1;
        check("reset_hold_inputs", {Cout, Sum}, 65'd0);
        reset_n = 1'b1;
        step("after_release", 64'd5, 64'd7, 1'b1);
        check("after_release_const", {Cout, Sum}, 65'd13);

        for (int unsigned i = 0; i < 10000; i++) begin
            logic [63:0] ra, rb;
            logic        rc;
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 1'($urandom_range(1, 0));
            step("random", ra, rb, rc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
